// File: rtl/handball_scorer_if.sv
`default_nettype none
// ============================================================================
// Module   : handball_scorer_if
// Purpose  : Bundles the game-control inputs (start, button, ball position)
//            and the score/lives/status outputs of the handball scorer.
//            The master side drives the inputs and the slave side (the
//            scorer) drives the results.
// Revision : 1.0  initial release
// ============================================================================
interface handball_scorer_if;
  logic       START;       // level-sensitive new-game request
  logic       PULSER;      // raw, asynchronous player button
  logic [7:0] LGOUT;       // ball position, bit 7 is the player end
  logic [7:0] SCORE;       // two BCD digits, saturating at 99
  logic [2:0] LIVES_LEFT;  // lives remaining in the current game
  logic       HIT;         // one-cycle pulse on a successful return
  logic       MISS;        // one-cycle pulse on a lost ball or foul
  logic       GAME_OVER;   // high while the game is over
  logic [7:0] HIGH;        // best BCD score since reset

  // Stimulus side: owns the game inputs and observes the results
  modport master (
    output START, PULSER, LGOUT,
    input  SCORE, LIVES_LEFT, HIT, MISS, GAME_OVER, HIGH
  );

  // Scorer side: consumes the game inputs and produces the results
  modport slave (
    input  START, PULSER, LGOUT,
    output SCORE, LIVES_LEFT, HIT, MISS, GAME_OVER, HIGH
  );
endinterface
`default_nettype wire

// File: rtl/handball_scorer.sv
`default_nettype none
// ============================================================================
// Module   : handball_scorer
// Purpose  : Scoring and lives controller for the handball game. Conditions
//            the player button (synchronize, debounce, edge-detect), judges
//            each ball return as a hit or a miss, and keeps the BCD score,
//            lives remaining, game-over status and high score.
// Revision : 1.0  initial release
// ============================================================================
module handball_scorer #(
  parameter int LIVES     = 3,  // misses allowed per game, 1..7
  parameter int DB_CYCLES = 4   // stable samples before the button changes, 1..255
) (
  input  logic              CLKK,
  input  logic              RESET,
  handball_scorer_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Types and constants
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // waiting for the first START after reset
    ST_PLAY   = 2'd1,  // ball in flight away from the player end
    ST_WINDOW = 2'd2,  // ball at the player end, a press counts as a hit
    ST_OVER   = 2'd3   // no lives left, frozen until START
  } state_e;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [7:0] DB_LIMIT   = 8'(DB_CYCLES);
  localparam logic [7:0] SCORE_MAX  = 8'h99;

  // --------------------------------------------------------------------------
  // Button conditioning state
  // --------------------------------------------------------------------------
  logic [1:0] sync_q,    sync_d;     // [0] first stage, [1] synchronized value
  logic [7:0] db_cnt_q,  db_cnt_d;   // consecutive mismatch count
  logic       db_val_q,  db_val_d;   // debounced button level
  logic       db_prev_q, db_prev_d;  // debounced level one cycle ago
  logic       press;                 // one-cycle rising edge of debounced level

  // --------------------------------------------------------------------------
  // Game state
  // --------------------------------------------------------------------------
  state_e     state_q,   state_d;
  logic [7:0] score_q,   score_d;
  logic [2:0] lives_q,   lives_d;
  logic       hit_q,     hit_d;
  logic       miss_q,    miss_d;
  logic       over_q,    over_d;
  logic [7:0] high_q,    high_d;
  logic       hflag_q,   hflag_d;    // a hit has been scored in this window
  logic       lose_life;             // this cycle costs a life

  // Only the player-end bit of the ball bus matters; the rest is ignored.
  logic       ball_at_player;
  logic       lgout_unused;

  assign ball_at_player = bus.LGOUT[7];
  assign lgout_unused   = ^bus.LGOUT[6:0];

  // --------------------------------------------------------------------------
  // BCD increment of a two-digit score, saturating at 99
  // --------------------------------------------------------------------------
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == SCORE_MAX) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Synchronize, debounce and edge-detect the raw button.
  always_comb begin
    sync_d    = {sync_q[0], bus.PULSER};
    db_cnt_d  = 8'd0;
    db_val_d  = db_val_q;
    db_prev_d = db_val_q;
    // A change is accepted only after DB_CYCLES consecutive disagreeing
    // samples; any agreeing sample restarts the count from zero.
    if (sync_q[1] != db_val_q) begin
      if ((db_cnt_q + 8'd1) >= DB_LIMIT) begin
        db_val_d = sync_q[1];
        db_cnt_d = 8'd0;
      end else begin
        db_cnt_d = db_cnt_q + 8'd1;
      end
    end
  end

  assign press = db_val_q & ~db_prev_q;

  // Next-state and next-output logic for the game state machine.
  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    lives_d   = lives_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    over_d    = over_q;
    high_d    = high_q;
    hflag_d   = hflag_q;
    lose_life = 1'b0;

    if (bus.START) begin
      // New game request overrides everything, including an open window,
      // which is simply discarded without costing a life.
      state_d = ST_PLAY;
      score_d = 8'h00;
      lives_d = LIVES_INIT;
      over_d  = 1'b0;
      hflag_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Nothing happens until a game is started.
        end

        ST_PLAY: begin
          if (ball_at_player) begin
            state_d = ST_WINDOW;
            hflag_d = 1'b0;
          end else if (press) begin
            // Swinging while the ball is away is a foul.
            lose_life = 1'b1;
          end
        end

        ST_WINDOW: begin
          if (!ball_at_player) begin
            // Window closes; a press in this same cycle is too late and is
            // not also treated as a foul, so at most one MISS results.
            state_d = ST_PLAY;
            if (!hflag_q) begin
              lose_life = 1'b1;
            end
          end else if (press && !hflag_q) begin
            hit_d   = 1'b1;
            score_d = bcd_inc(score_q);
            hflag_d = 1'b1;
          end
        end

        ST_OVER: begin
          // Outputs hold until the next START.
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (lose_life) begin
        miss_d = 1'b1;
        if (lives_q != 3'd0) begin
          lives_d = lives_q - 3'd1;
        end
        // Losing the last life ends the game and records a new best score.
        if (lives_q <= 3'd1) begin
          state_d = ST_OVER;
          over_d  = 1'b1;
          if (score_q > high_q) begin
            high_d = score_q;
          end
        end
      end
    end
  end

  // Register button conditioning and game state; async active-low clear.
  always_ff @(posedge CLKK or negedge RESET) begin
    if (!RESET) begin
      sync_q    <= 2'b00;
      db_cnt_q  <= 8'd0;
      db_val_q  <= 1'b0;
      db_prev_q <= 1'b0;
      state_q   <= ST_IDLE;
      score_q   <= 8'h00;
      lives_q   <= 3'd0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      over_q    <= 1'b0;
      high_q    <= 8'h00;
      hflag_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      db_cnt_q  <= db_cnt_d;
      db_val_q  <= db_val_d;
      db_prev_q <= db_prev_d;
      state_q   <= state_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      over_q    <= over_d;
      high_q    <= high_d;
      hflag_q   <= hflag_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs are driven straight from registers
  // --------------------------------------------------------------------------
  assign bus.SCORE      = score_q;
  assign bus.LIVES_LEFT = lives_q;
  assign bus.HIT        = hit_q;
  assign bus.MISS       = miss_q;
  assign bus.GAME_OVER  = over_q;
  assign bus.HIGH       = high_q;

endmodule
`default_nettype wire

// File: tb/tb_handball_scorer.sv
`default_nettype none
// ============================================================================
// Module   : tb_handball_scorer
// Purpose  : Directed self-checking bench for handball_scorer with default
//            parameters (LIVES=3, DB_CYCLES=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_handball_scorer;

  logic CLKK;
  logic RESET;

  handball_scorer_if bus ();

  handball_scorer #(
    .LIVES     (3),
    .DB_CYCLES (4)
  ) dut (
    .CLKK  (CLKK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLKK = 1'b0;
  always #5 CLKK = ~CLKK;

  int n_cmp = 0;
  int n_err = 0;
  int hit_cnt = 0;
  int miss_cnt = 0;
  int both_cnt = 0;
  int h0;
  int m0;

  // Count output pulses on the falling edge, away from the active edge
  always @(negedge CLKK) begin
    if (bus.HIT)             hit_cnt  <= hit_cnt + 1;
    if (bus.MISS)            miss_cnt <= miss_cnt + 1;
    if (bus.HIT && bus.MISS) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLKK);
      #1;
    end
  endtask

  task automatic snap();
    h0 = hit_cnt;
    m0 = miss_cnt;
  endtask

  task automatic start_game();
    bus.START = 1'b1;
    tick(2);
    bus.START = 1'b0;
    tick(1);
  endtask

  // One full window with a clean press well inside it
  task automatic do_hit();
    bus.LGOUT  = 8'h80;
    tick(2);
    bus.PULSER = 1'b1;
    tick(8);
    bus.PULSER = 1'b0;
    tick(8);
    bus.LGOUT  = 8'h00;
    tick(2);
  endtask

  // One window with no press at all
  task automatic empty_window();
    bus.LGOUT = 8'h80;
    tick(4);
    bus.LGOUT = 8'h00;
    tick(2);
  endtask

  initial begin
    RESET      = 1'b0;
    bus.START  = 1'b0;
    bus.PULSER = 1'b0;
    bus.LGOUT  = 8'h00;
    tick(3);

    // Reset state
    chk("rst_score", bus.SCORE, 8'h00);
    chk("rst_lives", bus.LIVES_LEFT, 3'd0);
    chk("rst_over",  bus.GAME_OVER, 1'b0);
    chk("rst_high",  bus.HIGH, 8'h00);
    chk("rst_hit",   bus.HIT, 1'b0);
    chk("rst_miss",  bus.MISS, 1'b0);
    RESET = 1'b1;
    tick(2);

    // START held: button and ball activity must not score or cost lives
    snap();
    bus.START  = 1'b1;
    bus.LGOUT  = 8'h80;
    tick(2);
    bus.PULSER = 1'b1;
    tick(8);
    bus.PULSER = 1'b0;
    bus.LGOUT  = 8'h00;
    tick(10);
    bus.START  = 1'b0;
    tick(1);
    chk("start_score", bus.SCORE, 8'h00);
    chk("start_lives", bus.LIVES_LEFT, 3'd3);
    chk("start_over",  bus.GAME_OVER, 1'b0);
    chk("start_high",  bus.HIGH, 8'h00);
    chk("start_hits",  hit_cnt - h0, 0);
    chk("start_miss",  miss_cnt - m0, 0);

    // One hit, a second press in the same window, then a clean close
    snap();
    bus.LGOUT  = 8'h80;
    tick(3);
    bus.PULSER = 1'b1;
    tick(8);
    chk("hit1_cnt",   hit_cnt - h0, 1);
    chk("hit1_score", bus.SCORE, 8'h01);
    bus.PULSER = 1'b0;
    tick(8);
    bus.PULSER = 1'b1;
    tick(8);
    bus.PULSER = 1'b0;
    tick(8);
    chk("hit2_cnt",   hit_cnt - h0, 1);
    chk("hit2_score", bus.SCORE, 8'h01);
    bus.LGOUT = 8'h00;
    tick(3);
    chk("close_miss",  miss_cnt - m0, 0);
    chk("close_lives", bus.LIVES_LEFT, 3'd3);

    // Short glitch is rejected; a 5-cycle press away from the end is a foul
    snap();
    bus.LGOUT  = 8'h01;
    bus.PULSER = 1'b1;
    tick(2);
    bus.PULSER = 1'b0;
    tick(10);
    chk("glitch_hit",   hit_cnt - h0, 0);
    chk("glitch_miss",  miss_cnt - m0, 0);
    chk("glitch_lives", bus.LIVES_LEFT, 3'd3);
    bus.PULSER = 1'b1;
    tick(5);
    bus.PULSER = 1'b0;
    tick(12);
    chk("foul_miss",  miss_cnt - m0, 1);
    chk("foul_lives", bus.LIVES_LEFT, 3'd2);
    chk("foul_score", bus.SCORE, 8'h01);
    bus.LGOUT = 8'h00;

    // Three unreturned balls end a fresh game with high score still 00
    start_game();
    chk("ng_score", bus.SCORE, 8'h00);
    chk("ng_lives", bus.LIVES_LEFT, 3'd3);
    snap();
    empty_window();
    chk("lose1_lives", bus.LIVES_LEFT, 3'd2);
    chk("lose1_over",  bus.GAME_OVER, 1'b0);
    empty_window();
    chk("lose2_lives", bus.LIVES_LEFT, 3'd1);
    empty_window();
    chk("lose3_lives", bus.LIVES_LEFT, 3'd0);
    chk("lose3_over",  bus.GAME_OVER, 1'b1);
    chk("lose3_high",  bus.HIGH, 8'h00);
    chk("lose3_miss",  miss_cnt - m0, 3);

    // Game over: presses and ball movement are ignored
    snap();
    bus.PULSER = 1'b1;
    tick(8);
    bus.PULSER = 1'b0;
    tick(8);
    do_hit();
    chk("over_hit",   hit_cnt - h0, 0);
    chk("over_miss",  miss_cnt - m0, 0);
    chk("over_lives", bus.LIVES_LEFT, 3'd0);
    chk("over_flag",  bus.GAME_OVER, 1'b1);

    // Ten hits roll the BCD score over to 10, then lose to record the high
    start_game();
    snap();
    for (int i = 0; i < 9; i++) do_hit();
    chk("bcd_09", bus.SCORE, 8'h09);
    do_hit();
    chk("bcd_10",   bus.SCORE, 8'h10);
    chk("bcd_hits", hit_cnt - h0, 10);
    chk("bcd_miss", miss_cnt - m0, 0);
    for (int i = 0; i < 3; i++) empty_window();
    chk("hi_over", bus.GAME_OVER, 1'b1);
    chk("hi_high", bus.HIGH, 8'h10);
    start_game();
    chk("hi_score_clr", bus.SCORE, 8'h00);
    chk("hi_keep",      bus.HIGH, 8'h10);
    chk("hi_lives",     bus.LIVES_LEFT, 3'd3);

    // Saturation at 99
    snap();
    for (int i = 0; i < 99; i++) do_hit();
    chk("sat_99", bus.SCORE, 8'h99);
    do_hit();
    chk("sat_hold", bus.SCORE, 8'h99);
    chk("sat_miss", miss_cnt - m0, 0);

    // Press arriving exactly as the ball leaves the end: one MISS, no HIT
    snap();
    bus.LGOUT  = 8'h80;
    tick(1);
    bus.PULSER = 1'b1;
    tick(6);
    bus.LGOUT  = 8'h00;
    tick(3);
    bus.PULSER = 1'b0;
    tick(10);
    chk("edge_hit",   hit_cnt - h0, 0);
    chk("edge_miss",  miss_cnt - m0, 1);
    chk("edge_lives", bus.LIVES_LEFT, 3'd2);
    chk("edge_score", bus.SCORE, 8'h99);

    // START during an open window discards it without a MISS
    snap();
    bus.LGOUT = 8'h80;
    tick(3);
    bus.START = 1'b1;
    tick(1);
    bus.LGOUT = 8'h00;
    tick(2);
    bus.START = 1'b0;
    tick(3);
    chk("swin_miss",  miss_cnt - m0, 0);
    chk("swin_lives", bus.LIVES_LEFT, 3'd3);

    chk("hit_miss_excl", both_cnt, 0);

    // Asynchronous reset in the middle of a window clears everything at once
    do_hit();
    bus.LGOUT  = 8'h80;
    tick(3);
    bus.PULSER = 1'b1;
    tick(3);
    RESET = 1'b0;
    #2;
    chk("arst_score", bus.SCORE, 8'h00);
    chk("arst_lives", bus.LIVES_LEFT, 3'd0);
    chk("arst_high",  bus.HIGH, 8'h00);
    chk("arst_over",  bus.GAME_OVER, 1'b0);
    chk("arst_hit",   bus.HIT, 1'b0);
    chk("arst_miss",  bus.MISS, 1'b0);
    bus.PULSER = 1'b0;
    bus.LGOUT  = 8'h00;
    tick(2);
    RESET = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/handball_scorer.md
Name: handball_scorer

Overview:
- Scoring and lives controller that sits directly downstream of the handball LED shift stage.
- Consumes the 8-bit LED ball-position bus (LGOUT) and the raw player button (PULSER).
- Conditions the button, judges each return as a hit or a miss, and keeps BCD score, lives remaining, game-over status and high score for the display stage.

Parameters:
- LIVES, 3, misses allowed per game; legal range 1..7.
- DB_CYCLES, 4, consecutive equal synchronized samples required before the debounced button changes; legal range 1..255.

Ports:
- CLKK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  synchronous new-game request, level-sensitive.
- PULSER  in  1  raw player button, asynchronous, active-high.
- LGOUT  in  8  ball position from the shift stage; bit 7 is the player end.
- SCORE  out  8  two BCD digits, 00..99, saturating.
- LIVES_LEFT  out  3  lives remaining.
- HIT  out  1  one-cycle pulse on a successful return.
- MISS  out  1  one-cycle pulse on a lost ball or foul.
- GAME_OVER  out  1  level; high in OVER state.
- HIGH  out  8  best BCD score since reset.

Behaviour:
- Reset (RESET=0, async): state IDLE; SCORE=00, LIVES_LEFT=0, HIT=0, MISS=0, GAME_OVER=0, HIGH=00; synchronizer, debounce counter and debounced button value cleared.
- Button path:
  - 2-FF synchronizer feeds an 8-bit debounce counter.
  - When the synchronized value differs from the debounced value for DB_CYCLES consecutive cycles, the debounced value takes the new value; any mismatch break clears the counter.
  - press = rising edge of the debounced value, one cycle wide.
  - Latency from a clean PULSER rise to press = 2 + DB_CYCLES cycles (DB_CYCLES=4 gives 6).
- START:
  - While START=1, in any state: SCORE=00, LIVES_LEFT=LIVES, GAME_OVER=0, HIT=MISS=0, next state PLAY. HIGH is kept.
  - START has priority over every other event.
  - Play evaluation begins on the first cycle with START=0.
- State machine (IDLE, PLAY, WINDOW, OVER):
  - IDLE: ignores LGOUT and press; leaves only via START.
  - PLAY, LGOUT[7]=1: enter WINDOW and clear the hit flag.
  - PLAY, press with LGOUT[7]=0: foul. MISS pulses and LIVES_LEFT decrements.
  - WINDOW, press with LGOUT[7]=1 and hit flag clear: HIT pulses, SCORE increments in BCD (09 goes to 10; held at 99), hit flag sets. Further presses in the same window are ignored.
  - WINDOW, LGOUT[7]=0: window closes and state returns to PLAY. If the hit flag is clear, MISS pulses and LIVES_LEFT decrements.
  - Any decrement that makes LIVES_LEFT reach 0: next state OVER and GAME_OVER=1. If SCORE>HIGH (plain 8-bit compare, valid for BCD), HIGH takes SCORE on the same edge.
  - OVER: press and LGOUT are ignored, outputs hold, and the state is left only via START.
- Boundary rules:
  - Press in the same cycle LGOUT[7] falls: not a hit. Exactly one MISS results (window-close miss), not an additional foul.
  - Only LGOUT[7] is examined. Other bits, including multiple set bits or all-zero, have no effect.
  - LIVES_LEFT never underflows.
  - HIT and MISS are never high in the same cycle.
  - Async reset mid-game forces the reset values immediately, including HIGH.
  - START asserted during a window discards that window with no MISS.

Test Plan:
- Reset then START pulse -> SCORE=00, LIVES_LEFT=3, GAME_OVER=0, HIGH=00; with START held, PULSER activity produces no HIT or MISS.
- LGOUT[7] high for 10 cycles; clean PULSER rise 2 cycles after window opens (press at cycle 8, inside window) -> one HIT, SCORE=01; second press in same window -> no change; window close -> no MISS.
- PULSER glitch of 2 cycles with DB_CYCLES=4 -> no press, no HIT, no MISS; a 5-cycle stable press with LGOUT=8'h01 -> MISS (foul), LIVES_LEFT=2.
- Three windows with no press -> MISS on each close, LIVES_LEFT 3->2->1->0, GAME_OVER=1 on the third close, HIGH=00; later presses ignored until START.
- Ten hits -> SCORE=10 (BCD rollover); game then lost -> HIGH=10; START -> SCORE=00, HIGH=10; force 99 hits -> SCORE held at 99.
- Press edge coinciding with LGOUT[7] falling -> single MISS, no HIT; RESET low mid-window -> all outputs zero within the same cycle.
